// File: rtl/wdog_pkg.sv
// ---------------------------------------------------------------------------
// wdog_pkg
// Shared types and constants for the hang-detection watchdog.
//   wdog_state_t : controller state encoding (also the State output encoding)
//   WDOG_CNTW    : default width of the stall counter and threshold
// ---------------------------------------------------------------------------
package wdog_pkg;

    localparam int WDOG_CNTW = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WARN    = 2'b10,
        EXPIRED = 2'b11
    } wdog_state_t;

endpackage

// File: rtl/wdog_if.sv
// ---------------------------------------------------------------------------
// wdog_if
// Signal bundle between the testbench top (master) and wdog_ctrl (slave).
//   master drives : PCW, InstrValidW, Arm, Disarm, Pause, LoadThresh, ThreshIn
//   slave drives  : State, Warn, Expired, StuckPC, Count
// ---------------------------------------------------------------------------
interface wdog_if #(
    parameter int XLEN = 64,
    parameter int CNTW = wdog_pkg::WDOG_CNTW
);
    logic [XLEN-1:0] PCW;
    logic            InstrValidW;
    logic            Arm;
    logic            Disarm;
    logic            Pause;
    logic            LoadThresh;
    logic [CNTW-1:0] ThreshIn;
    logic [1:0]      State;
    logic            Warn;
    logic            Expired;
    logic [XLEN-1:0] StuckPC;
    logic [CNTW-1:0] Count;

    modport master (
        output PCW, InstrValidW, Arm, Disarm, Pause, LoadThresh, ThreshIn,
        input  State, Warn, Expired, StuckPC, Count
    );

    modport slave (
        input  PCW, InstrValidW, Arm, Disarm, Pause, LoadThresh, ThreshIn,
        output State, Warn, Expired, StuckPC, Count
    );
endinterface

// File: rtl/wdog_progress.sv
// ---------------------------------------------------------------------------
// wdog_progress
// Holds the last retired PC and flags forward progress.
//   clk, reset  : clock, synchronous active-high reset
//   en          : allows LastPCW to update (low once the watchdog expired)
//   load        : capture PCW unconditionally (arming)
//   pc          : writeback-stage PC
//   instr_valid : instruction retired this cycle
//   progress    : retire of a PC different from the last retired one
//   last_pc     : last retired / captured PC (flop output)
// ---------------------------------------------------------------------------
module wdog_progress
    import wdog_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [XLEN-1:0] pc,
    input  logic            instr_valid,
    output logic            progress,
    output logic [XLEN-1:0] last_pc
);

    // A spin loop retiring the same PC is not progress.
    assign progress = instr_valid && (pc != last_pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc <= '0;
        end else if (en && (instr_valid || load)) begin
            last_pc <= pc;
        end
    end

endmodule

// File: rtl/wdog_ctrl.sv
// ---------------------------------------------------------------------------
// wdog_ctrl
// Testbench hang detector: counts cycles without forward progress at
// writeback and sequences IDLE -> ARMED -> (WARN) -> EXPIRED.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wdog_if.slave (PCW/InstrValidW probes, Arm/Disarm/Pause,
//                LoadThresh/ThreshIn, State/Warn/Expired/StuckPC/Count)
// Build option: define WDOG_WARN_EN to enable the WARN state and Warn output;
// without it ARMED goes straight to EXPIRED and Warn is tied low.
// ---------------------------------------------------------------------------
module wdog_ctrl
    import wdog_pkg::*;
#(
    parameter int            XLEN                   = 64,
    parameter int            CNTW                   = WDOG_CNTW,
    parameter logic [CNTW-1:0] WatchDogTimerThreshold = CNTW'(1000000)
) (
    input logic   clk,
    input logic   reset,
    wdog_if.slave bus
);

    wdog_state_t     state_q, state_next;
    logic [CNTW-1:0] count_q, count_next, count_d;
    logic [CNTW-1:0] thresh_q;
    logic            warn_q, warn_d;
    logic            expired_q, expired_d;
    logic            progress;
    logic            expire_c, warn_c;
    logic            arm_load;
    logic [XLEN-1:0] last_pc;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign arm_load = (state_q == IDLE) && bus.Arm && !bus.Disarm;

    wdog_progress #(.XLEN(XLEN)) u_progress (
        .clk         (clk),
        .reset       (reset),
        .en          (state_q != EXPIRED),
        .load        (arm_load),
        .pc          (bus.PCW),
        .instr_valid (bus.InstrValidW),
        .progress    (progress),
        .last_pc     (last_pc)
    );

    // Candidate count for this edge; progress beats Pause.
    always_comb begin
        count_next = sat_inc(count_q);
        if (progress)       count_next = '0;
        else if (bus.Pause) count_next = count_q;
    end

    assign expire_c = (thresh_q != '0) && (count_next >= thresh_q);
`ifdef WDOG_WARN_EN
    assign warn_c = (count_next != '0) && (count_next >= (thresh_q >> 1)) && !expire_c;
`else
    assign warn_c = 1'b0;
`endif

    // FSM next state; Disarm outranks expiry.
    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (arm_load) state_next = ARMED;
            ARMED: begin
                if (bus.Disarm)    state_next = IDLE;
                else if (expire_c) state_next = EXPIRED;
                else if (warn_c)   state_next = WARN;
            end
            WARN: begin
                if (bus.Disarm)    state_next = IDLE;
                else if (expire_c) state_next = EXPIRED;
                else if (progress) state_next = ARMED;
            end
            default:               state_next = EXPIRED;
        endcase
    end

    // FSM outputs, registered so nothing reaches the ports combinationally.
    always_comb begin
        warn_d    = (state_next == WARN);
        expired_d = (state_next == EXPIRED);
        count_d   = count_next;
        if (state_q == EXPIRED)                          count_d = count_q;
        else if (state_q == IDLE || state_next == IDLE)  count_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            thresh_q  <= WatchDogTimerThreshold;
            warn_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_next;
            count_q   <= count_d;
            warn_q    <= warn_d;
            expired_q <= expired_d;
            if (bus.LoadThresh && state_q != EXPIRED) thresh_q <= bus.ThreshIn;
        end
    end

    assign bus.State   = state_q;
    assign bus.Warn    = warn_q;
    assign bus.Expired = expired_q;
    assign bus.Count   = count_q;
    // LastPCW stops updating in EXPIRED, so it doubles as the frozen StuckPC.
    assign bus.StuckPC = last_pc;

endmodule
